// File: rtl/pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// pipeline_sequencer
//
// Flow-control sequencer for the three-stage arithmetic-encoder pipeline.
// It tracks a valid bit for each pipeline stage and produces one global stall
// from downstream back-pressure. At end of frame it drains the pipeline, asks
// the final range/low flush logic to run, and then pulses frame completion.
//
// Configuration macro:
//   PIPELINE_SEQ_SYMCNT_EN  defined   -> per-frame accepted-symbol counter
//                           undefined -> counter omitted, sym_count reads 0
//
// Ports:
//   clk                 single clock, rising edge
//   reset_ctrl          synchronous active-high reset
//   in_valid / in_last  symbol present at stage-1 input / last of frame
//   in_ready            symbol accepted this cycle when in_valid is high
//   out_ready           downstream packer takes the final-register contents
//   out_valid           final pipeline register holds a valid result
//   pipeline_reg_1_2    load enable, stage 1 -> 2 register
//   pipeline_reg_2_3    load enable, stage 2 -> 3 register
//   pipeline_reg_final  load enable, final register
//   stage_valid         {final, 2_3, 1_2} valid bits
//   flush_req           level request to the final flush logic
//   flush_ack           flush logic finished (only looked at in FLUSH)
//   frame_done          one-cycle end-of-frame pulse
//   sym_count           symbols accepted in the current frame
// -----------------------------------------------------------------------------
module pipeline_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_ctrl,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   input  logic             out_ready,
   output logic             out_valid,
   output logic             pipeline_reg_1_2,
   output logic             pipeline_reg_2_3,
   output logic             pipeline_reg_final,
   output logic [2:0]       stage_valid,
   output logic             flush_req,
   input  logic             flush_ack,
   output logic             frame_done,
   output logic [CNT_W-1:0] sym_count
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t     state_q;
   logic [2:0] v_q;
   logic [2:0] v_d;
   logic       flush_req_q;
   logic       frame_done_q;
   logic       advance;
   logic       accept;

   // The only way to stall is a full final register that downstream refuses;
   // every stage then holds so no bubble appears on release.
   assign advance = ~v_q[2] | out_ready;
   assign in_ready = advance & (state_q == RUN);
   assign accept = in_valid & in_ready;
   assign v_d = advance ? {v_q[1:0], accept} : v_q;

   assign pipeline_reg_1_2   = advance;
   assign pipeline_reg_2_3   = advance;
   assign pipeline_reg_final = advance;
   assign stage_valid        = v_q;
   assign out_valid          = v_q[2];
   assign flush_req          = flush_req_q;
   assign frame_done         = frame_done_q;

   always_ff @(posedge clk) begin
      if (reset_ctrl) begin
         state_q      <= RUN;
         v_q          <= 3'b000;
         flush_req_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         v_q          <= v_d;
         frame_done_q <= 1'b0;
         case (state_q)
            RUN: begin
               if (accept && in_last) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               // Leave as the last result is handed downstream, so flush_req
               // can never precede the final output handshake.
               if (v_d == 3'b000) begin
                  state_q     <= FLUSH;
                  flush_req_q <= 1'b1;
               end
            end
            FLUSH: begin
               if (flush_ack) begin
                  state_q      <= DONE;
                  flush_req_q  <= 1'b0;
                  frame_done_q <= 1'b1;
               end
            end
            DONE: begin
               state_q <= RUN;
            end
            default: begin
               state_q <= RUN;
            end
         endcase
      end
   end

`ifdef PIPELINE_SEQ_SYMCNT_EN
   logic [CNT_W-1:0] sym_count_q;

   always_ff @(posedge clk) begin
      if (reset_ctrl) begin
         sym_count_q <= '0;
      end else if (state_q == DONE) begin
         sym_count_q <= '0;
      end else if (accept && (sym_count_q != {CNT_W{1'b1}})) begin
         sym_count_q <= sym_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign sym_count = sym_count_q;
`else
   assign sym_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
module tb_pipeline_sequencer;

   localparam int CNT_W = 16;
   localparam int PH_RUN = 0, PH_DRAIN = 1, PH_FLUSH = 2, PH_DONE = 3;

   logic             clk = 1'b0;
   logic             reset_ctrl = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_last = 1'b0;
   logic             in_ready;
   logic             out_ready = 1'b1;
   logic             out_valid;
   logic             pipeline_reg_1_2;
   logic             pipeline_reg_2_3;
   logic             pipeline_reg_final;
   logic [2:0]       stage_valid;
   logic             flush_req;
   logic             flush_ack = 1'b0;
   logic             frame_done;
   logic [CNT_W-1:0] sym_count;
   logic [7:0]       in_data = 8'd0;

   always #5 clk = ~clk;

   pipeline_sequencer #(.CNT_W(CNT_W)) dut (
      .clk               (clk),
      .reset_ctrl        (reset_ctrl),
      .in_valid          (in_valid),
      .in_last           (in_last),
      .in_ready          (in_ready),
      .out_ready         (out_ready),
      .out_valid         (out_valid),
      .pipeline_reg_1_2  (pipeline_reg_1_2),
      .pipeline_reg_2_3  (pipeline_reg_2_3),
      .pipeline_reg_final(pipeline_reg_final),
      .stage_valid       (stage_valid),
      .flush_req         (flush_req),
      .flush_ack         (flush_ack),
      .frame_done        (frame_done),
      .sym_count         (sym_count)
   );

   // Bench-side data path clocked by the DUT's enables: if the enables are
   // right, symbols come out of d3 in acceptance order.
   logic [7:0] d1, d2, d3;
   always @(posedge clk) begin
      if (pipeline_reg_1_2)   d1 <= in_data;
      if (pipeline_reg_2_3)   d2 <= d1;
      if (pipeline_reg_final) d3 <= d2;
   end

   int pass_cnt = 0;
   int total_cnt = 0;

   function automatic void check(string name, int act, int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endfunction

   // Reference model: three slots holding symbol values (-1 = empty),
   // a frame phase, and an accepted-symbol count.
   int pipe [3];
   int m_ph;
   int m_cnt;
   int exp_q [$];
   bit m_acc;

   task automatic model_reset();
      for (int i = 0; i < 3; i++) pipe[i] = -1;
      m_ph = PH_RUN;
      m_cnt = 0;
      exp_q.delete();
   endtask

   // One clock cycle: inputs already driven; check at negedge, advance model.
   task automatic step();
      bit adv, ir, acc, empty;
      int exp_cnt;
      @(negedge clk);
      adv = (pipe[2] < 0) || out_ready;
      ir  = adv && (m_ph == PH_RUN);
      acc = in_valid && ir;
`ifdef PIPELINE_SEQ_SYMCNT_EN
      exp_cnt = m_cnt;
`else
      exp_cnt = 0;
`endif
      check("stage_valid", int'(stage_valid),
            int'({pipe[2] >= 0, pipe[1] >= 0, pipe[0] >= 0}));
      check("out_valid", int'(out_valid), int'(pipe[2] >= 0));
      check("in_ready", int'(in_ready), int'(ir));
      check("enables", int'({pipeline_reg_final, pipeline_reg_2_3, pipeline_reg_1_2}),
            adv ? 7 : 0);
      check("flush_req", int'(flush_req), int'(m_ph == PH_FLUSH));
      check("frame_done", int'(frame_done), int'(m_ph == PH_DONE));
      check("sym_count", int'(sym_count), exp_cnt);

      if (reset_ctrl) begin
         model_reset();
         acc = 1'b0;
      end else begin
         if (acc) exp_q.push_back(int'(in_data));
         if (adv) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = acc ? int'(in_data) : -1;
         end
         if (m_ph == PH_DONE) m_cnt = 0;
         else if (acc && m_cnt < (1 << CNT_W) - 1) m_cnt++;
         empty = (pipe[0] < 0) && (pipe[1] < 0) && (pipe[2] < 0);
         case (m_ph)
            PH_RUN:   if (acc && in_last) m_ph = PH_DRAIN;
            PH_DRAIN: if (empty) m_ph = PH_FLUSH;
            PH_FLUSH: if (flush_ack) m_ph = PH_DONE;
            default:  m_ph = PH_RUN;
         endcase
      end
      m_acc = acc;
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every output handshake pops the oldest expected symbol.
   always @(negedge clk) begin
      if (!reset_ctrl && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) check("sb_unexpected_output", int'(d3), -1);
         else check("sb_data", int'(d3), exp_q.pop_front());
      end
   end

   task automatic do_reset(int n);
      reset_ctrl = 1'b1;
      in_valid = 1'b0;
      in_last = 1'b0;
      flush_ack = 1'b0;
      repeat (n) step();
      reset_ctrl = 1'b0;
   endtask

   task automatic run_frame(int n, int ack_delay, int stall_pct, int gap_pct);
      int sent = 0;
      int budget = 0;
      int fl_cnt = 0;
      bit done = 1'b0;
      while (sent < n && budget < 500) begin
         in_valid  = ($urandom_range(0, 99) >= gap_pct);
         in_last   = (sent == n - 1);
         in_data   = 8'($urandom_range(0, 255));
         out_ready = ($urandom_range(0, 99) >= stall_pct);
         flush_ack = 1'($urandom_range(0, 1));
         step();
         if (m_acc) sent++;
         budget++;
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      while (!done && budget < 500) begin
         out_ready = ($urandom_range(0, 99) >= stall_pct);
         if (m_ph == PH_FLUSH) begin
            flush_ack = (fl_cnt >= ack_delay);
            fl_cnt++;
         end else begin
            flush_ack = 1'($urandom_range(0, 1));
         end
         if (m_ph == PH_DONE) done = 1'b1;
         step();
         budget++;
      end
      check("frame_complete", int'(done), 1);
      flush_ack = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      int budget;
      model_reset();
      @(posedge clk);
      #1;
      do_reset(2);

      // Five back-to-back symbols, no back-pressure, then drain.
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data = 8'($urandom_range(0, 255));
         step();
      end
      in_valid = 1'b0;
      repeat (5) step();

      // Continuous input with a 4-cycle stall once the pipeline is full.
      for (int i = 0; i < 15; i++) begin
         in_valid = 1'b1;
         in_data = 8'($urandom_range(0, 255));
         out_ready = !(i >= 4 && i < 8);
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (5) step();

      // Three-symbol frame, ack two cycles after flush_req rises.
      run_frame(3, 2, 0, 0);
      // Immediate ack on the first FLUSH cycle, and stalls during drain.
      run_frame(2, 0, 0, 0);
      run_frame(4, 1, 50, 0);

      // Reset while in FLUSH with an empty pipeline.
      in_valid = 1'b1;
      in_last = 1'b1;
      in_data = 8'($urandom_range(0, 255));
      step();
      in_valid = 1'b0;
      in_last = 1'b0;
      budget = 0;
      while (m_ph != PH_FLUSH && budget < 20) begin
         step();
         budget++;
      end
      check("reached_flush", m_ph, PH_FLUSH);
      step();
      do_reset(1);
      repeat (3) step();

      // Reset while in RUN with all three stages full.
      budget = 0;
      while (!(pipe[0] >= 0 && pipe[1] >= 0 && pipe[2] >= 0) && budget < 20) begin
         in_valid = 1'b1;
         in_data = 8'($urandom_range(0, 255));
         step();
         budget++;
      end
      check("pipe_filled", int'(pipe[2] >= 0), 1);
      do_reset(1);
      repeat (3) step();

      // Randomized frames.
      for (int f = 0; f < 15; f++) begin
         run_frame(int'($urandom_range(1, 8)), int'($urandom_range(0, 3)), 30, 20);
      end
      repeat (5) step();

      check("sb_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Flow-control sequencer for the three-stage arithmetic-encoder pipeline. Replaces the fixed fill-only enable schedule with per-stage valid tracking and a single global stall driven by downstream back-pressure. Also sequences end-of-frame: drains the pipeline, hands off to the final range/low flush logic, and reports frame completion. Sits between the symbol source and the encoder datapath; its enables drive the 1→2, 2→3 and final pipeline registers directly.

## Interface
- `CNT_W`, 16: width of the per-frame accepted-symbol counter.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset_ctrl`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  symbol present at stage-1 input.
- `in_last`  in  1  qualifies `in_valid`: last symbol of the frame.
- `in_ready`  out  1  sequencer accepts a symbol this cycle.
- `out_ready`  in  1  downstream bitstream packer accepts the final-register contents.
- `out_valid`  out  1  final pipeline register holds a valid result.
- `pipeline_reg_1_2`, `pipeline_reg_2_3`, `pipeline_reg_final`  out  1 each  register load enables.
- `stage_valid`  out  3  {final, 2_3, 1_2} valid bits.
- `flush_req`  out  1  level request to the final flush logic.
- `flush_ack`  in  1  flush logic finished; sampled only in FLUSH.
- `frame_done`  out  1  one-cycle pulse at end of frame.
- `sym_count`  out  CNT_W  symbols accepted in the current frame.

## Operation
- `v[2:0]` = `stage_valid`; `out_valid` = `v[2]`.
- `advance` = `~v[2] | out_ready` (global stall only when the final register is full and not accepted).
- All three enables = `advance`; every register shifts together when enabled, holds otherwise.
- `in_ready` = `advance` & (state == RUN). Accept = `in_valid & in_ready`.
- On `advance`: `v[0] <= accept`, `v[1] <= v[0]`, `v[2] <= v[1]`. Otherwise `v` holds.
- States: RUN, DRAIN, FLUSH, DONE.
  - RUN: accept with `in_last` = 1 → DRAIN. `in_last` without accept is ignored.
  - DRAIN: `in_ready` = 0; pipeline advances normally. Leaves to FLUSH on the cycle where `v` next-value is 000, i.e. the last result fires (`v[2] & out_ready`) with `v[1:0]` = 00.
  - FLUSH: `flush_req` = 1. `flush_ack` = 1 → DONE. `flush_ack` outside FLUSH has no effect.
  - DONE: `frame_done` = 1 for this one cycle; `in_ready` = 0; → RUN.
- Arithmetic: `sym_count` increments by 1 per accept, saturates at 2^CNT_W−1, clears to 0 on the DONE cycle (next cycle reads 0).

## Timing
- Reset values: state RUN, `v` = 000, `out_valid` 0, `flush_req` 0, `frame_done` 0, `sym_count` 0; enables = 1 and `in_ready` = 1 during the cycle after reset (combinational from `v` = 000).
- Latency: symbol accepted at edge t is in the final register, `out_valid` = 1, after edge t+3 absent stalls. One symbol per cycle throughput.
- Stall: `out_valid` & ~`out_ready` freezes all stages and `in_ready` in the same cycle; no bubble is inserted on release.
- Frame with last symbol accepted at t and no stalls: FLUSH entered after edge t+4, `flush_req` high from then; DONE one cycle after `flush_ack`; next frame accepted the cycle after DONE.
- `flush_ack` high on the first FLUSH cycle: FLUSH lasts one cycle.
- Reset mid-frame (any state): in-flight data discarded (`v` cleared), `flush_req` dropped, no `frame_done`, counter cleared.

## Configuration
- `PIPELINE_SEQ_SYMCNT_EN`: defined → `sym_count` counter implemented as above. Undefined → counter logic omitted, `sym_count` tied to 0; all other behaviour identical.

## Test plan
- Reset then 5 back-to-back symbols, `out_ready` = 1 → first `out_valid` 3 cycles after first accept, 5 consecutive valid outputs, `v` returns to 000.
- Continuous input, `out_ready` low for 4 cycles while `v` = 111 → `in_ready` and all enables 0 for exactly those 4 cycles, no data lost/duplicated, order preserved.
- Frame of 3 symbols, last with `in_last`, `flush_ack` 2 cycles after `flush_req` → `in_ready` 0 from DRAIN, `flush_req` high 3 cycles, single `frame_done` pulse, `sym_count` 3 before DONE, 0 after.
- `out_ready` dropped during DRAIN → DRAIN extends until final output fires; `flush_req` never precedes last `out_valid` handshake.
- `flush_ack` asserted during RUN and DRAIN → ignored; asserted first FLUSH cycle → DONE next cycle.
- `reset_ctrl` pulsed during FLUSH with `v` = 000 and during RUN with `v` = 111 → next cycle state RUN, `v` = 000, `flush_req` 0, `frame_done` never asserted.
